// File: rtl/sc_statemachine_point_ctrl_pkg.sv
// rtl/sc_statemachine_point_ctrl_pkg.sv - shared states, shift codes and counter sizing for the point controller
package sc_point_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_LOAD  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_RUN   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    localparam logic [1:0] SHIFT_NONE = 2'b00;
    localparam logic [1:0] SHIFT_MSB  = 2'b01;
    localparam logic [1:0] SHIFT_LSB  = 2'b10;

    function automatic int cnt_width(input int tick_count);
        return $clog2(tick_count);
    endfunction

endpackage

// File: rtl/sc_statemachine_point_ctrl_if.sv
// rtl/sc_statemachine_point_ctrl_if.sv - button inputs, register strobes and readback between controller and board
interface sc_statemachine_point_ctrl_if #(
    parameter int DATAWIDTH = 8
);
    logic                 start_InLow;
    logic                 pause_InLow;
    logic                 left_InLow;
    logic                 right_InLow;
    logic [DATAWIDTH-1:0] data_InBUS;
    logic                 clear_OutLow;
    logic                 load_OutLow;
    logic [1:0]           shiftselection_Out;
    logic [DATAWIDTH-1:0] data0_OutBUS;
    logic                 upcount_Out;
    logic [2:0]           state_Out;

    modport master (
        input  start_InLow, pause_InLow, left_InLow, right_InLow, data_InBUS,
        output clear_OutLow, load_OutLow, shiftselection_Out, data0_OutBUS,
               upcount_Out, state_Out
    );

    modport slave (
        output start_InLow, pause_InLow, left_InLow, right_InLow, data_InBUS,
        input  clear_OutLow, load_OutLow, shiftselection_Out, data0_OutBUS,
               upcount_Out, state_Out
    );
endinterface

// File: rtl/sc_statemachine_point_ctrl_edgedetect_fall.sv
// rtl/sc_statemachine_point_ctrl_edgedetect_fall.sv - one-cycle pulse on a 1-to-0 transition of an active-low level
module sc_edgedetect_fall (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic fall
);
    logic prev;

    // History resets high so a button already held at reset does not fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign fall = prev & ~level;
endmodule

// File: rtl/sc_statemachine_point_ctrl.sv
// rtl/sc_statemachine_point_ctrl.sv - clear/load/rotate sequencer for the point-type shift register
module sc_statemachine_point_ctrl
    import sc_point_pkg::*;
#(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   TICK_COUNT = 25000000,
    parameter logic [DATAWIDTH-1:0] INIT_POINT = 8'b00010000
) (
    input  logic                        SC_RegPOINTTYPE_CLOCK_50,
    input  logic                        SC_RegPOINTTYPE_RESET_InHigh,
    sc_statemachine_point_ctrl_if.master bus
);
    localparam int            CW        = cnt_width(TICK_COUNT);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_COUNT - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          dir, dir_n;
    logic          start_ev, pause_ev, left_ev, right_ev;
    logic          clear_l, load_l, upcount;
    logic [1:0]    shift_sel;

    sc_edgedetect_fall u_start (.clk(SC_RegPOINTTYPE_CLOCK_50), .rst(SC_RegPOINTTYPE_RESET_InHigh),
                                .level(bus.start_InLow), .fall(start_ev));
    sc_edgedetect_fall u_pause (.clk(SC_RegPOINTTYPE_CLOCK_50), .rst(SC_RegPOINTTYPE_RESET_InHigh),
                                .level(bus.pause_InLow), .fall(pause_ev));
    sc_edgedetect_fall u_left  (.clk(SC_RegPOINTTYPE_CLOCK_50), .rst(SC_RegPOINTTYPE_RESET_InHigh),
                                .level(bus.left_InLow), .fall(left_ev));
    sc_edgedetect_fall u_right (.clk(SC_RegPOINTTYPE_CLOCK_50), .rst(SC_RegPOINTTYPE_RESET_InHigh),
                                .level(bus.right_InLow), .fall(right_ev));

    always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
        if (SC_RegPOINTTYPE_RESET_InHigh) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dir   <= dir_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        dir_n     = dir;
        clear_l   = 1'b1;
        load_l    = 1'b1;
        shift_sel = SHIFT_NONE;
        upcount   = 1'b0;

        // Simultaneous left and right cancel out and keep the current direction.
        if ((state == ST_RUN) || (state == ST_SHIFT)) begin
            if (left_ev && !right_ev) begin
                dir_n = 1'b0;
            end else if (right_ev && !left_ev) begin
                dir_n = 1'b1;
            end
        end

        case (state)
            ST_CLEAR: begin
                clear_l = 1'b0;
                cnt_n   = '0;
                state_n = ST_LOAD;
            end
            ST_LOAD: begin
                load_l  = 1'b0;
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
            ST_IDLE: begin
                cnt_n = '0;
                if (start_ev) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // Pause takes precedence so a tick in the same cycle is deferred, not lost.
                if (pause_ev) begin
                    state_n = ST_PAUSE;
                end else if (bus.data_InBUS == '0) begin
                    state_n = ST_CLEAR;
                end else if (cnt == TICK_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_SHIFT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_SHIFT: begin
                shift_sel = dir ? SHIFT_LSB : SHIFT_MSB;
                upcount   = 1'b1;
                cnt_n     = cnt + CW'(1);
                state_n   = ST_RUN;
            end
            ST_PAUSE: begin
                if (pause_ev) begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_CLEAR;
            end
        endcase
    end

    assign bus.clear_OutLow       = clear_l;
    assign bus.load_OutLow        = load_l;
    assign bus.shiftselection_Out = shift_sel;
    assign bus.upcount_Out        = upcount;
    assign bus.data0_OutBUS       = INIT_POINT;
    assign bus.state_Out          = state;
endmodule

// File: doc/sc_statemachine_point_ctrl.md
# sc_statemachine_point_ctrl

Control FSM driving the point-type shift register from the register's own side of the interface. Generates the active-low clear and load strobes and the 2-bit rotate command, and reads back the register contents to detect a lost point. Converts debounced start, pause and direction buttons plus an internal tick prescaler into one-cycle register commands. Sits between the board button conditioners and the point register.

## Interface
- DATAWIDTH, 8, width of the register data bus.
- TICK_COUNT, 25000000, clock cycles between automatic shifts (0.5 s at 50 MHz); must be ≥ 2.
- INIT_POINT, 8'b00010000, pattern loaded after clear.
- SC_RegPOINTTYPE_CLOCK_50  in  1  system clock, 50 MHz.
- SC_RegPOINTTYPE_RESET_InHigh  in  1  reset, asynchronous, active-high.
- start_InLow  in  1  debounced start button, active-low level.
- pause_InLow  in  1  debounced pause toggle button, active-low level.
- left_InLow  in  1  debounced direction-left button, active-low level.
- right_InLow  in  1  debounced direction-right button, active-low level.
- data_InBUS  in  DATAWIDTH  register readback.
- clear_OutLow  out  1  register clear strobe, active-low.
- load_OutLow  out  1  register load strobe, active-low.
- shiftselection_Out  out  2  00 hold, 01 rotate toward MSB, 10 rotate toward LSB.
- data0_OutBUS  out  DATAWIDTH  load value; constant INIT_POINT.
- upcount_Out  out  1  one-cycle pulse per issued shift.
- state_Out  out  3  current state encoding, for debug.

## Operation
- Button events: falling edge of the synchronous level (previous sample 1, current sample 0). Holding a button produces one event.
- States and Moore outputs. Strobes not listed are inactive: clear/load = 1, shift = 00, upcount = 0.
  - ST_CLEAR: clear_OutLow = 0. Next state ST_LOAD.
  - ST_LOAD: load_OutLow = 0. Next state ST_IDLE.
  - ST_IDLE: tick counter held at 0. A start event goes to ST_RUN.
  - ST_RUN: counter increments. Exits in priority order:
    - pause event → ST_PAUSE;
    - data_InBUS == 0 → ST_CLEAR;
    - counter == TICK_COUNT-1 → ST_SHIFT, and counter wraps to 0.
  - ST_SHIFT: shiftselection_Out = dir ? 10 : 01, upcount_Out = 1. Counter keeps incrementing. Next state ST_RUN.
  - ST_PAUSE: counter frozen. A pause event goes to ST_RUN with the counter value unchanged.
- Direction register dir: 0 = toward MSB, 1 = toward LSB.
  - Left event sets dir = 0; right event sets dir = 1.
  - Both events in the same cycle leave dir unchanged.
  - Events are honoured in ST_RUN and ST_SHIFT, ignored in all other states.
- A direction event in the tick cycle takes effect on that tick's shift.
- Pause event and tick in the same cycle: pause wins and no shift is issued. The counter holds at TICK_COUNT-1, so the shift fires in the first ST_RUN cycle after resume.
- Start events outside ST_IDLE are ignored.
- Encodings: ST_CLEAR = 0, ST_LOAD = 1, ST_IDLE = 2, ST_RUN = 3, ST_SHIFT = 4, ST_PAUSE = 5.
- Unused encodings 6 and 7 go to ST_CLEAR.

## Timing
- Reset values: state ST_CLEAR, so clear_OutLow = 0, load_OutLow = 1, shiftselection_Out = 00, upcount_Out = 0, state_Out = 0. Also dir = 0, counter = 0, edge-detector history = 1.
- Reset released at edge 0: ST_LOAD after edge 1, ST_IDLE after edge 2. The register holds INIT_POINT after edge 2.
- Start event in cycle k: ST_RUN from edge k+1. First ST_SHIFT TICK_COUNT cycles later, then every TICK_COUNT cycles while running.
- The register rotates on the edge ending ST_SHIFT, so shifts are spaced exactly TICK_COUNT cycles apart.
- Button-to-strobe latency is zero extra cycles: outputs are decoded from state only, with no output registers.
- Reset asserted mid-operation: immediate return to ST_CLEAR; counter and dir reinitialised.
- Lost point (data_InBUS == 0 in ST_RUN): ST_CLEAR, then ST_LOAD, then ST_IDLE. Three cycles total, and a new start event is required.

## Structure
- Package sc_point_pkg holds:
  - state localparams ST_CLEAR … ST_PAUSE;
  - shift codes SHIFT_NONE = 2'b00, SHIFT_MSB = 2'b01, SHIFT_LSB = 2'b10;
  - the counter width expression $clog2(TICK_COUNT).
- One sub-module, sc_edgedetect_fall: a 1-bit registered falling-edge pulse generator with reset value 1, instantiated four times.
- Top level contains the state register, next-state logic, counter, dir register and output decode.

## Test plan
- Reset then release, INIT_POINT = 8'h10, register model attached → clear_OutLow low in cycle 0, load_OutLow low in cycle 1, state_Out = 2 and register = 8'h10 from cycle 2.
- TICK_COUNT = 4, start event, no direction event → upcount pulse every 4 cycles with shiftselection 01; register sequence 8'h20, 8'h40, 8'h80, 8'h01.
- Running, right event in a tick cycle → that shift uses 10; register 8'h10 → 8'h08. Left and right pressed together → dir unchanged.
- Pause event coinciding with a tick → no upcount pulse. Counter frozen for 10 cycles. After a resume event, the shift occurs in the first ST_RUN cycle.
- Force data_InBUS = 0 during ST_RUN → ST_CLEAR, ST_LOAD, ST_IDLE in three cycles; a later start event resumes running.
- Assert reset during ST_SHIFT → shiftselection_Out = 00 and clear_OutLow = 0 immediately, with no clock edge required.
